// File: rtl/serial_seq_detector_if.sv
// Serial detector bus: sampled bit, enable, and detector status outputs.
// master drives din/en; slave (the detector) drives the status signals.
interface serial_seq_detector_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic             din;
    logic             en;
    logic [N-1:0]     shreg;
    logic             primed;
    logic             match;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output din, en,
        input  shreg, primed, match, match_cnt
    );

    modport slave (
        input  din, en,
        output shreg, primed, match, match_cnt
    );
endinterface

// File: rtl/serial_seq_detector.sv
// serial_seq_detector: shifts enabled din bits into an N-bit register and
// pulses match when the last N fresh bits equal PATTERN (MSB = oldest bit).
// Matches are counted in a saturating CNT_W-bit counter.
// Optional macro SEQ_OVERLAP_EN: overlapping detection (bits reused across
// matches). Without it, each match restarts the fill so the next hit needs
// N fresh bits; the restart lands on the edge after the match edge, so
// primed is still 1 during the match cycle.
module serial_seq_detector #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter int           CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    serial_seq_detector_if.slave  bus
);
    localparam int            FW   = $clog2(N + 1);
    localparam logic [FW-1:0] FULL = FW'(N);

    typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

    state_t           state;
    logic [N-1:0]     shreg_q;
    logic [FW-1:0]    fill_q;
    logic             primed_q;
    logic             match_q;
    logic [CNT_W-1:0] cnt_q;

    state_t           state_base;
    logic [FW-1:0]    fill_base;
    logic [FW-1:0]    fill_nxt;
    logic [N-1:0]     sh_nxt;
    logic             hit;

    // Next-bit view: state/fill after any pending restart, plus the shifted value
    always_comb begin
        sh_nxt = {shreg_q[N-2:0], bus.din};
`ifdef SEQ_OVERLAP_EN
        state_base = state;
        fill_base  = fill_q;
`else
        // match_q high means the previous edge completed a hit: start over
        state_base = match_q ? FILL : state;
        fill_base  = match_q ? '0   : fill_q;
`endif
        fill_nxt = (state_base == ARMED) ? FULL : fill_base + 1'b1;
        hit      = bus.en && (fill_nxt == FULL) && (sh_nxt == PATTERN);
    end

    // Detector FSM, shift register, fill count and match counter
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            shreg_q  <= '0;
            fill_q   <= '0;
            primed_q <= 1'b0;
            match_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            match_q <= hit;
            if (bus.en) begin
                shreg_q  <= sh_nxt;
                fill_q   <= fill_nxt;
                primed_q <= (fill_nxt == FULL);
                state    <= (fill_nxt == FULL) ? ARMED : FILL;
                if (hit && (cnt_q != '1))
                    cnt_q <= cnt_q + 1'b1;
            end else begin
                // Data holds; only a pending restart is applied
                fill_q   <= fill_base;
                primed_q <= (fill_base == FULL);
                state    <= state_base;
            end
        end
    end

    assign bus.shreg     = shreg_q;
    assign bus.primed    = primed_q;
    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;
endmodule
